// File: rtl/cpu_int_ctrl_pkg.sv
// rtl/cpu_int_ctrl_pkg.sv - shared interrupt kind codes, default vectors and sequencer states
package cpu_int_ctrl_pkg;

    localparam logic [1:0] INT_KIND_NONE  = 2'b00;
    localparam logic [1:0] INT_KIND_RESET = 2'b01;
    localparam logic [1:0] INT_KIND_NMI   = 2'b10;
    localparam logic [1:0] INT_KIND_IRQ   = 2'b11;

    localparam logic [15:0] DEF_RESET_VEC = 16'hFFFC;
    localparam logic [15:0] DEF_NMI_VEC   = 16'hFFFA;
    localparam logic [15:0] DEF_IRQ_VEC   = 16'hFFFE;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TAKEN = 1'b1
    } int_state_t;

endpackage

// File: rtl/cpu_int_ctrl_sync.sv
// rtl/cpu_int_ctrl_sync.sv - int_sync: STAGES-deep, WIDTH-wide synchroniser resetting to all ones
module int_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '1;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/cpu_int_ctrl.sv
// rtl/cpu_int_ctrl.sv - interrupt/reset sequencer for the 2A03-class core
// Optional BRK/IRQ-to-NMI vector hijack while waiting for ack: CPU_INT_NMI_HIJACK_EN
module cpu_int_ctrl
    import cpu_int_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ     = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] RESET_VEC   = DEF_RESET_VEC,
    parameter logic [15:0] NMI_VEC     = DEF_NMI_VEC,
    parameter logic [15:0] IRQ_VEC     = DEF_IRQ_VEC
) (
    input  logic               clock,
    input  logic               nreset,
    input  logic               nnmi,
    input  logic [NUM_IRQ-1:0] nirq_src,
    input  logic               flag_i,
    input  logic               poll,
    input  logic               brk,
    input  logic               ack,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic               int_take,
    output logic [1:0]         int_kind,
    output logic [15:0]        int_vec,
    output logic               int_set_b,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic [NUM_IRQ-1:0] irq_mask
);

    logic               nmi_s;
    logic [NUM_IRQ-1:0] nirq_s;
    logic               nmi_prev;
    logic               nmi_edge;
    logic               nmi_latch;
    logic               reset_latch;
    logic               irq_line;
    logic               ack_taken;
    int_state_t         state_q, state_d;
    logic [1:0]         kind_q, kind_d;
    logic [15:0]        vec_q, vec_d;
    logic               set_b_q, set_b_d;

    int_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_nmi_sync (
        .clock  (clock),
        .nreset (nreset),
        .d      (nnmi),
        .q      (nmi_s)
    );

    int_sync #(.WIDTH(NUM_IRQ), .STAGES(SYNC_STAGES)) u_irq_sync (
        .clock  (clock),
        .nreset (nreset),
        .d      (nirq_src),
        .q      (nirq_s)
    );

    assign nmi_edge    = nmi_prev & ~nmi_s;
    assign irq_pending = ~nirq_s & irq_mask;
    assign irq_line    = |irq_pending;
    assign ack_taken   = (state_q == ST_TAKEN) && ack;

    // A fresh NMI edge beats the clearing ack so back-to-back NMIs are never dropped.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            nmi_prev    <= 1'b1;
            nmi_latch   <= 1'b0;
            reset_latch <= 1'b1;
            irq_mask    <= '1;
        end else begin
            nmi_prev <= nmi_s;
            if (nmi_edge) begin
                nmi_latch <= 1'b1;
            end else if (ack_taken && kind_q == INT_KIND_NMI) begin
                nmi_latch <= 1'b0;
            end
            if (ack_taken && kind_q == INT_KIND_RESET) begin
                reset_latch <= 1'b0;
            end
            if (mask_we) begin
                irq_mask <= mask_wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            kind_q  <= INT_KIND_NONE;
            vec_q   <= RESET_VEC;
            set_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            vec_q   <= vec_d;
            set_b_q <= set_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        vec_d   = vec_q;
        set_b_d = set_b_q;
        case (state_q)
            ST_IDLE: begin
                if (poll) begin
                    if (reset_latch) begin
                        state_d = ST_TAKEN;
                        kind_d  = INT_KIND_RESET;
                        vec_d   = RESET_VEC;
                        set_b_d = 1'b0;
                    end else if (nmi_latch) begin
                        state_d = ST_TAKEN;
                        kind_d  = INT_KIND_NMI;
                        vec_d   = NMI_VEC;
                        set_b_d = 1'b0;
                    end else if (irq_line && !flag_i) begin
                        state_d = ST_TAKEN;
                        kind_d  = INT_KIND_IRQ;
                        vec_d   = IRQ_VEC;
                        set_b_d = 1'b0;
                    end else if (brk) begin
                        state_d = ST_TAKEN;
                        kind_d  = INT_KIND_IRQ;
                        vec_d   = IRQ_VEC;
                        set_b_d = 1'b1;
                    end
                end
            end
            ST_TAKEN: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end
`ifdef CPU_INT_NMI_HIJACK_EN
                // B keeps its value, so a hijacked BRK still pushes B = 1.
                else if (kind_q == INT_KIND_IRQ && nmi_latch) begin
                    kind_d = INT_KIND_NMI;
                    vec_d  = NMI_VEC;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign int_take  = (state_q == ST_TAKEN);
    assign int_kind  = kind_q;
    assign int_vec   = vec_q;
    assign int_set_b = set_b_q;

endmodule
